// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
//   master: controller side (samples opc/alu_zero/mem_ready, drives controls and debug)
//   slave : datapath/memory side
interface multicycle_ctrl_if;
    logic [5:0]  opc;
    logic        alu_zero;
    logic        mem_ready;
    logic        imemr;
    logic        ir_we;
    logic        pc_we;
    logic        m1;
    logic        m2;
    logic        m3;
    logic        m4;
    logic        regw;
    logic [1:0]  aluop;
    logic        dmemr;
    logic        dmemw;
    logic [2:0]  state;
    logic        illegal;
    logic [15:0] retire_cnt;
    modport master (
        input  opc, alu_zero, mem_ready,
        output imemr, ir_we, pc_we, m1, m2, m3, m4, regw, aluop, dmemr, dmemw,
               state, illegal, retire_cnt
    );
    modport slave (
        output opc, alu_zero, mem_ready,
        input  imemr, ir_we, pc_we, m1, m2, m3, m4, regw, aluop, dmemr, dmemw,
               state, illegal, retire_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle MIPS-style controller (R, LW, SW, BEQ, BNE).
//   clk, rst : clock and synchronous active-high reset
//   bus      : multicycle_ctrl_if.master (opc/alu_zero/mem_ready in; controls, state, illegal, retire_cnt out)
module multicycle_ctrl (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, BRANCH = 3'd5, HALT = 3'd6
    } state_t;
    typedef enum logic [2:0] {C_R, C_LW, C_SW, C_BEQ, C_BNE} cls_t;
    state_t      state_q, state_d;
    cls_t        cls_q, cls_d, dec_cls;
    logic        illegal_q, illegal_d;
    logic [15:0] retire_q, retire_d;
    logic        dec_ok, retire, taken, en;
    assign taken = (cls_q == C_BEQ && bus.alu_zero) || (cls_q == C_BNE && !bus.alu_zero);
    always_comb begin
        dec_ok  = 1'b1;
        dec_cls = C_R;
        case (bus.opc)
            6'b000000: dec_cls = C_R;
            6'b100011: dec_cls = C_LW;
            6'b101011: dec_cls = C_SW;
            6'b000100: dec_cls = C_BEQ;
            6'b000101: dec_cls = C_BNE;
            default:   dec_ok  = 1'b0;
        endcase
    end
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        retire    = 1'b0;
        case (state_q)
            FETCH:  state_d = bus.mem_ready ? DECODE : FETCH;
            DECODE: begin
                cls_d     = dec_ok ? dec_cls : cls_q;
                illegal_d = illegal_q | !dec_ok;
                state_d   = !dec_ok ? HALT : (dec_cls == C_BEQ || dec_cls == C_BNE) ? BRANCH : EXEC;
            end
            EXEC:   state_d = cls_q == C_R ? WB : MEM;
            MEM: begin
                // SW retires straight out of MEM; LW still needs its writeback cycle
                retire  = bus.mem_ready && cls_q != C_LW;
                state_d = !bus.mem_ready ? MEM : cls_q == C_LW ? WB : FETCH;
            end
            WB: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
        retire_d = retire_q + 16'(retire);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            cls_q     <= C_R;
            illegal_q <= 1'b0;
            retire_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            illegal_q <= illegal_d;
            retire_q  <= retire_d;
        end
    end
    // every enable, request and mux select is held low while rst is asserted
    assign en             = !rst;
    assign bus.imemr      = en && state_q == FETCH;
    assign bus.ir_we      = en && state_q == FETCH && bus.mem_ready;
    assign bus.pc_we      = en && ((state_q == FETCH && bus.mem_ready) || (state_q == BRANCH && taken));
    assign bus.m4         = en && state_q == BRANCH && taken;
    assign bus.m1         = en && (state_q == EXEC || state_q == WB) && cls_q == C_R;
    assign bus.m2         = en && ((state_q == EXEC && cls_q != C_R) || state_q == MEM);
    assign bus.m3         = en && state_q == WB && cls_q == C_LW;
    assign bus.regw       = en && state_q == WB;
    assign bus.aluop      = !en ? 2'b00 : state_q == BRANCH ? 2'b11 :
                            (state_q == EXEC && cls_q != C_R) ? 2'b01 : 2'b00;
    assign bus.dmemr      = en && state_q == MEM && cls_q == C_LW;
    assign bus.dmemw      = en && state_q == MEM && cls_q == C_SW;
    assign bus.state      = state_q;
    assign bus.illegal    = illegal_q;
    assign bus.retire_cnt = retire_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: builds per-instruction expected cycle traces from timing rules and checks the controller every cycle.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
    localparam logic [11:0] IM = 12'h800, IRW = 12'h400, PCW = 12'h200, M1 = 12'h100, M2 = 12'h080,
                            M3 = 12'h040, M4 = 12'h020, RW = 12'h010, AA = 12'h004, AS = 12'h00C,
                            DR = 12'h002, DW = 12'h001, NONE = 12'h000;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_BAD = 6'b111111;
    typedef struct {
        logic        r;
        logic [5:0]  opc;
        logic        az;
        logic        mr;
        logic        pre;
        logic [2:0]  st;
        logic [11:0] o;
        logic        ill;
        logic [15:0] ret;
    } cyc_t;
    cyc_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] m_ret = 16'd0;
    logic        m_ill = 1'b0;
    logic        m_pre = 1'b0;
    task automatic chk(string n, int c, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", n, c, a, e);
        end
    endtask
    task automatic push(logic r, logic [5:0] op, logic az, logic mr, logic [2:0] st, logic [11:0] o);
        q.push_back('{r: r, opc: op, az: az, mr: mr, pre: m_pre, st: st, o: o, ill: m_ill, ret: m_ret});
        m_pre = 1'b0;
    endtask
    // fw/mw: mem_ready wait cycles in FETCH/MEM; opc is garbage and mem_ready high outside the cycles that use them
    task automatic instr(logic [5:0] op, int fw, int mw, logic az);
        for (int i = 0; i < fw; i++) push(1'b0, OP_BAD, az, 1'b0, 3'd0, IM);
        push(1'b0, OP_BAD, az, 1'b1, 3'd0, IM | IRW | PCW);
        push(1'b0, op, az, 1'b1, 3'd1, NONE);
        case (op)
            OP_R: begin
                push(1'b0, OP_BAD, az, 1'b1, 3'd2, M1);
                push(1'b0, OP_BAD, az, 1'b1, 3'd4, RW | M1);
                m_ret++;
            end
            OP_LW, OP_SW: begin
                push(1'b0, OP_BAD, az, 1'b1, 3'd2, AA | M2);
                for (int i = 0; i < mw; i++) push(1'b0, OP_BAD, az, 1'b0, 3'd3, M2 | (op == OP_LW ? DR : DW));
                push(1'b0, OP_BAD, az, 1'b1, 3'd3, M2 | (op == OP_LW ? DR : DW));
                if (op == OP_LW) push(1'b0, OP_BAD, az, 1'b1, 3'd4, RW | M3);
                m_ret++;
            end
            OP_BEQ, OP_BNE: begin
                push(1'b0, OP_BAD, az, 1'b1, 3'd5, AS | (((op == OP_BEQ) ? az : !az) ? (PCW | M4) : NONE));
                m_ret++;
            end
            default: m_ill = 1'b1;
        endcase
    endtask
    task automatic halt(int n);
        for (int i = 0; i < n; i++) push(1'b0, OP_R, 1'b1, 1'b1, 3'd6, NONE);
    endtask
    task automatic rst_cyc(logic [2:0] st);
        push(1'b1, OP_R, 1'b0, 1'b1, st, NONE);
        m_ill = 1'b0;
        m_ret = 16'd0;
    endtask
    task automatic sw_abort();
        push(1'b0, OP_BAD, 1'b0, 1'b1, 3'd0, IM | IRW | PCW);
        push(1'b0, OP_SW, 1'b0, 1'b1, 3'd1, NONE);
        push(1'b0, OP_BAD, 1'b0, 1'b1, 3'd2, AA | M2);
        push(1'b0, OP_BAD, 1'b0, 1'b0, 3'd3, M2 | DW);
        rst_cyc(3'd3);
    endtask
    initial begin
        int n0;
        int len[5];
        bus.opc = OP_R;
        bus.alu_zero = 1'b0;
        bus.mem_ready = 1'b0;
        rst_cyc(3'd0);
        rst_cyc(3'd0);
        n0 = q.size(); instr(OP_R, 0, 0, 1'b0);   len[0] = q.size() - n0;
        n0 = q.size(); instr(OP_LW, 0, 2, 1'b0);  len[1] = q.size() - n0;
        n0 = q.size(); instr(OP_BEQ, 0, 0, 1'b1); len[2] = q.size() - n0;
        n0 = q.size(); instr(OP_BNE, 0, 0, 1'b1); len[3] = q.size() - n0;
        instr(OP_BNE, 0, 0, 1'b0);
        instr(OP_BEQ, 0, 0, 1'b0);
        n0 = q.size(); instr(OP_SW, 1, 1, 1'b0);  len[4] = q.size() - n0;
        instr(OP_R, 2, 0, 1'b1);
        chk("model_len_r", 0, len[0], 4);
        chk("model_len_lw_w2", 0, len[1], 7);
        chk("model_len_beq", 0, len[2], 3);
        chk("model_len_bne", 0, len[3], 3);
        chk("model_len_sw_w2", 0, len[4], 6);
        chk("model_retires", 0, 32'(m_ret), 8);
        sw_abort();
        instr(OP_SW, 0, 0, 1'b0);
        instr(OP_BAD, 0, 0, 1'b0);
        halt(20);
        rst_cyc(3'd6);
        m_ret = 16'hFFFF;
        m_pre = 1'b1;
        instr(OP_SW, 0, 0, 1'b0);
        chk("model_wrap", 0, 32'(m_ret), 0);
        instr(OP_R, 0, 0, 1'b0);
        instr(OP_LW, 0, 0, 1'b1);
        @(posedge clk);
        #1;
        foreach (q[i]) begin
            rst = q[i].r;
            bus.opc = q[i].opc;
            bus.alu_zero = q[i].az;
            bus.mem_ready = q[i].mr;
            if (q[i].pre) force dut.retire_q = 16'hFFFF;
            @(negedge clk);
            chk("state", i, 32'(bus.state), 32'(q[i].st));
            chk("ctrl", i, 32'({bus.imemr, bus.ir_we, bus.pc_we, bus.m1, bus.m2, bus.m3, bus.m4,
                                bus.regw, bus.aluop, bus.dmemr, bus.dmemw}), 32'(q[i].o));
            chk("illegal", i, 32'(bus.illegal), 32'(q[i].ill));
            chk("retire_cnt", i, 32'(bus.retire_cnt), 32'(q[i].ret));
            chk("excl", i, 32'(int'(bus.imemr) + int'(bus.dmemr) + int'(bus.dmemw) > 1 || (bus.regw && bus.dmemw)), 0);
            if (q[i].pre) release dut.retire_q;
            @(posedge clk);
            #1;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
